axi_wr_burst_splitter: RTL and testbench
========================================

AXI_WR_BURST_SPLITTER -- requirements
Module: axi_wr_burst_splitter

Interface
REQ-001 Parameter ADDR_W, default 64: AXI address width.
REQ-002 Parameter DATA_W, default 128: data width; beat size BYTES = DATA_W/8; awsize = log2(BYTES).
REQ-003 Parameter LEN_W, default 8: awlen width; max burst MAXB = 2^LEN_W beats.
REQ-004 Parameter ID_W, default 4: AXI ID width.
REQ-005 Parameter TOTAL_LEN_W, default 16: command length width.
REQ-006 Parameter PAGE_SIZE_BYTES, default 4096: power of two; no burst crosses a page.
REQ-007 Parameter NUM_OUTSTANDING, default 2: maximum AW bursts issued without a B response.
REQ-008 Reset and clock: one clock; reset is asynchronous and active-high; ports are clk (input, 1, rising-edge clock) and rst (input, 1, asynchronous active-high reset).
REQ-009 Command ports: cmd_valid in 1; cmd_ready out 1; cmd_addr in ADDR_W; cmd_len in TOTAL_LEN_W (beats minus 1); cmd_id in ID_W.
REQ-010 AW ports: awvalid out 1; awready in 1; awaddr out ADDR_W; awlen out LEN_W; awsize out 3; awburst out 2; awid out ID_W.
REQ-011 B ports: bvalid in 1; bready in 1; bresp in 2. The block only observes these and never drives bready.
REQ-012 Done ports: done_valid out 1; done_ready in 1; done_resp out 2 (aggregated response).

Function
REQ-013 FSM states: IDLE, CALC, ISSUE, DRAIN, RESP.
REQ-014 IDLE: cmd_ready=1.
- On cmd handshake: latch addr with low log2(BYTES) bits forced to 0, latch rem=cmd_len+1, latch id, clear the error accumulator, go to CALC.
REQ-015 CALC: register the next burst in one cycle.
- beats = min(rem, MAXB, (PAGE_SIZE_BYTES - addr mod PAGE_SIZE_BYTES)/BYTES); awlen = beats-1.
- Go to ISSUE if out_cnt < NUM_OUTSTANDING; otherwise hold in CALC.
REQ-016 ISSUE: awvalid=1, and the AW fields stay stable until awready.
- On handshake: out_cnt+1; addr += beats*BYTES; rem -= beats.
- Next state is DRAIN if rem==0, otherwise CALC.
REQ-017 awsize is constant log2(BYTES); awburst is constant 2'b01 (INCR).
REQ-018 DRAIN: wait for out_cnt==0, then go to RESP.
REQ-019 RESP: done_valid=1 and done_resp=accumulator.
- On done_ready, go to IDLE.
- done_valid stays asserted until done_ready is high.
REQ-020 B counting: each bvalid&bready handshake decrements out_cnt in any state.
- A simultaneous AW handshake and B handshake leaves out_cnt unchanged.
- A B handshake while out_cnt==0 is ignored; out_cnt never underflows.
REQ-021 Response aggregation: treat EXOKAY (01) as OKAY (00); accumulator = max(accumulator, mapped bresp).
REQ-022 Address arithmetic wraps modulo 2^ADDR_W with no error. Minimum AW-to-AW spacing is 2 cycles (CALC+ISSUE).

Reset
REQ-023 While rst is high, all state clears asynchronously:
- State goes to IDLE; out_cnt, rem, accumulator and ID counter go to 0.
- awvalid=0, done_valid=0, cmd_ready=0.
REQ-024 cmd_ready goes to 1 in the first cycle after rst deasserts. A reset during a burst abandons that burst with no done indication.

Configuration
REQ-025 Macro AXI_ID_ROTATE_EN.
- Defined: awid = latched cmd_id + sub-burst index, modulo 2^ID_W; the first burst uses cmd_id.
- Undefined: every sub-burst uses cmd_id.

Verification
REQ-026 Page split: addr 0x0FF0, cmd_len 3, awready=1 -> bursts (0x0FF0, awlen 0) then (0x1000, awlen 2).
REQ-027 Max-burst split: addr 0x0, cmd_len 511 -> bursts (0x0000, awlen 255) then (0x1000, awlen 255); after 2 B handshakes, done_resp=00.
REQ-028 Outstanding limit: NUM_OUTSTANDING=2, cmd_len 767, B withheld.
- Third awvalid stays 0 until a B handshake.
- The third awvalid then rises within 2 cycles of that B handshake.
REQ-029 Response aggregation: bresp 01, 10, 00 over 3 bursts -> done_resp=10. bresp 11 on any burst -> done_resp=11.
REQ-030 Simultaneous events and reset:
- AW and B handshakes in the same cycle with out_cnt=1 -> out_cnt stays 1.
- rst asserted during ISSUE -> awvalid=0 immediately, and cmd_ready=1 the cycle after release.
REQ-031 ID rotation: cmd_id 4'hF, 2 bursts -> awid F then 0 with AXI_ID_ROTATE_EN; F then F without it.

Source files
------------

// File: rtl/axi_wr_burst_splitter.sv
// axi_wr_burst_splitter: splits a write command into page/max-burst bounded AW bursts and aggregates B responses.
// Define AXI_ID_ROTATE_EN to step awid by one per sub-burst; otherwise every sub-burst carries cmd_id.
module axi_wr_burst_splitter #(
  parameter int ADDR_W          = 64,
  parameter int DATA_W          = 128,
  parameter int LEN_W           = 8,
  parameter int ID_W            = 4,
  parameter int TOTAL_LEN_W     = 16,
  parameter int PAGE_SIZE_BYTES = 4096,
  parameter int NUM_OUTSTANDING = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic [ADDR_W-1:0]      cmd_addr_i,
  input  logic [TOTAL_LEN_W-1:0] cmd_len_i,
  input  logic [ID_W-1:0]        cmd_id_i,
  output logic                   awvalid_o,
  input  logic                   awready_i,
  output logic [ADDR_W-1:0]      awaddr_o,
  output logic [LEN_W-1:0]       awlen_o,
  output logic [2:0]             awsize_o,
  output logic [1:0]             awburst_o,
  output logic [ID_W-1:0]        awid_o,
  input  logic                   bvalid_i,
  input  logic                   bready_i,
  input  logic [1:0]             bresp_i,
  output logic                   done_valid_o,
  input  logic                   done_ready_i,
  output logic [1:0]             done_resp_o
);
  localparam int BYTES = DATA_W / 8;
  localparam int SZ    = $clog2(BYTES);
  localparam int PB    = $clog2(PAGE_SIZE_BYTES);
  localparam int RW    = TOTAL_LEN_W + 1;
  localparam int CW    = $clog2(NUM_OUTSTANDING + 1);
  localparam int MAXB  = 1 << LEN_W;
  typedef enum logic [2:0] {IDLE, CALC, ISSUE, DRAIN, RESP} state_t;
  state_t            st_q;
  logic [ADDR_W-1:0] addr_q;
  logic [RW-1:0]     rem_q;
  logic [ID_W-1:0]   awid_q;
  logic [LEN_W:0]    beats_q, beats_d;
  logic [LEN_W-1:0]  awlen_q;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [1:0]        acc_q, acc_d;
  logic              cmd_ready_q, awvalid_q, done_valid_q;
  logic [31:0]       pg_d, cap_d;
  logic              aw_hs, b_hs;
  always_comb begin
    aw_hs   = awvalid_q & awready_i;
    b_hs    = bvalid_i & bready_i;
    pg_d    = (32'(PAGE_SIZE_BYTES) - 32'(addr_q[PB-1:0])) >> SZ;
    cap_d   = (32'(rem_q) < 32'(MAXB)) ? 32'(rem_q) : 32'(MAXB);
    beats_d = (LEN_W+1)'((pg_d < cap_d) ? pg_d : cap_d);
    cnt_d   = cnt_q + CW'(aw_hs) - CW'(b_hs && cnt_q != '0);
    // EXOKAY ranks as OKAY, so it never raises the accumulator
    acc_d   = (b_hs && bresp_i != 2'b01 && bresp_i > acc_q) ? bresp_i : acc_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q         <= IDLE;
      addr_q       <= '0;
      rem_q        <= '0;
      awid_q       <= '0;
      beats_q      <= '0;
      awlen_q      <= '0;
      cnt_q        <= '0;
      acc_q        <= '0;
      cmd_ready_q  <= 1'b0;
      awvalid_q    <= 1'b0;
      done_valid_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      case (st_q)
        IDLE: begin
          if (cmd_ready_q && cmd_valid_i) begin
            cmd_ready_q <= 1'b0;
            addr_q      <= cmd_addr_i & ~ADDR_W'(BYTES - 1);
            rem_q       <= RW'(cmd_len_i) + 1'b1;
            awid_q      <= cmd_id_i;
            acc_q       <= '0;
            st_q        <= CALC;
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end
        CALC: begin
          beats_q <= beats_d;
          awlen_q <= LEN_W'(beats_d - 1'b1);
          if (cnt_q < CW'(NUM_OUTSTANDING)) begin
            awvalid_q <= 1'b1;
            st_q      <= ISSUE;
          end
        end
        ISSUE: begin
          if (awready_i) begin
            awvalid_q <= 1'b0;
            addr_q    <= addr_q + (ADDR_W'(beats_q) << SZ);
            rem_q     <= rem_q - RW'(beats_q);
`ifdef AXI_ID_ROTATE_EN
            awid_q    <= awid_q + 1'b1;
`endif
            st_q      <= (rem_q == RW'(beats_q)) ? DRAIN : CALC;
          end
        end
        DRAIN: begin
          if (cnt_q == '0) begin
            done_valid_q <= 1'b1;
            st_q         <= RESP;
          end
        end
        RESP: begin
          if (done_ready_i) begin
            done_valid_q <= 1'b0;
            cmd_ready_q  <= 1'b1;
            st_q         <= IDLE;
          end
        end
        default: st_q <= IDLE;
      endcase
    end
  end
  assign cmd_ready_o  = cmd_ready_q;
  assign awvalid_o    = awvalid_q;
  assign awaddr_o     = addr_q;
  assign awlen_o      = awlen_q;
  assign awsize_o     = 3'(SZ);
  assign awburst_o    = 2'b01;
  assign awid_o       = awid_q;
  assign done_valid_o = done_valid_q;
  assign done_resp_o  = acc_q;
endmodule

// File: tb/tb_axi_wr_burst_splitter.sv
// tb_axi_wr_burst_splitter: random and directed commands checked against a burst-list reference model.
module tb_axi_wr_burst_splitter;
  localparam int BY = 16;
  localparam int PAGE = 4096;
  localparam int NO = 2;
  logic clk = 1'b0, rst = 1'b1;
  logic cmd_valid = 0, cmd_ready, awvalid, awready = 0, bvalid = 0, bready = 0;
  logic done_valid, done_ready = 0;
  logic [63:0] cmd_addr = '0, awaddr;
  logic [15:0] cmd_len = '0;
  logic [3:0]  cmd_id = '0, awid;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst, bresp = '0, done_resp;
  int n_chk = 0, n_bad = 0;
  typedef struct {logic [63:0] a; logic [7:0] l; logic [3:0] id;} burst_t;
  burst_t q[$];
  logic [1:0] s2[3] = '{2'b01, 2'b10, 2'b00};
  logic [1:0] s3[3] = '{2'b00, 2'b11, 2'b00};
  always #5 clk = ~clk;
  axi_wr_burst_splitter dut (
    .clk(clk), .rst(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_addr_i(cmd_addr),
    .cmd_len_i(cmd_len), .cmd_id_i(cmd_id),
    .awvalid_o(awvalid), .awready_i(awready), .awaddr_o(awaddr), .awlen_o(awlen),
    .awsize_o(awsize), .awburst_o(awburst), .awid_o(awid),
    .bvalid_i(bvalid), .bready_i(bready), .bresp_i(bresp),
    .done_valid_o(done_valid), .done_ready_i(done_ready), .done_resp_o(done_resp)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic build(input logic [63:0] addr, input logic [15:0] len, input logic [3:0] id);
    logic [63:0] a;
    int rem, pg, b, k;
    q.delete();
    a = addr & ~64'(BY - 1);
    rem = int'(len) + 1;
    k = 0;
    while (rem > 0) begin
      pg = (PAGE - int'(a[11:0])) / BY;
      b = rem < 256 ? rem : 256;
      b = pg < b ? pg : b;
`ifdef AXI_ID_ROTATE_EN
      q.push_back('{a, 8'(b - 1), id + 4'(k)});
`else
      q.push_back('{a, 8'(b - 1), id});
`endif
      a = a + 64'(b * BY);
      rem -= b;
      k++;
    end
  endtask
  task automatic issue_cmd(input logic [63:0] addr, input logic [15:0] len, input logic [3:0] id);
    int t;
    @(negedge clk);
    cmd_valid = 1; cmd_addr = addr; cmd_len = len; cmd_id = id;
    t = 0;
    while (!cmd_ready && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) chk("cmd_accept_timeout", 0, 1);
    @(negedge clk);
    cmd_valid = 0;
  endtask
  task automatic run_cmd(input logic [63:0] addr, input logic [15:0] len, input logic [3:0] id,
                         input int mode, input bit hold);
    int pend, naw, nb, hp, hc;
    logic [1:0] acc, m;
    logic [63:0] pa;
    bit pv, aw_hs, b_hs, fin;
    burst_t e;
    build(addr, len, id);
    issue_cmd(addr, len, id);
    pend = 0; naw = 0; nb = 0; hp = hold ? 1 : 0; hc = 0; acc = 0; pv = 0; fin = 0; pa = '0;
    for (int cyc = 0; cyc < 6000 && !fin; cyc++) begin
      if (pv) begin
        chk("aw_stable_valid", awvalid, 1);
        chk("aw_stable_addr", awaddr, pa);
      end
      if (hp == 2) begin
        hc++;
        if (awvalid) begin chk("aw3_latency", hc <= 2, 1); hp = 0; end
        else if (hc > 2) begin chk("aw3_latency", 0, 1); hp = 0; end
      end
      awready = (hp != 0) ? 1'b1 : ($urandom % 4 != 0);
      if (hp != 0) begin bvalid = 0; bready = 0; end
      else begin bvalid = pend > 0 && ($urandom % 3 != 0); bready = ($urandom % 4 != 0); end
      if (hp == 1 && naw == 2) begin
        hc++;
        chk("aw_held_at_limit", awvalid, 0);
        if (hc == 10) begin bvalid = 1; bready = 1; hp = 2; hc = 0; end
      end
      bresp = mode == 2 ? s2[nb % 3] : mode == 3 ? s3[nb % 3] :
              mode == 0 ? 2'($urandom % 2) : 2'($urandom % 4);
      done_ready = ($urandom % 2 != 0);
      aw_hs = awvalid && awready;
      b_hs = bvalid && bready;
      if (aw_hs) begin
        chk("aw_outstanding", pend < NO, 1);
        if (q.size() == 0) chk("aw_extra_burst", 1, 0);
        else begin
          e = q.pop_front();
          chk("awaddr", awaddr, e.a);
          chk("awlen", awlen, e.l);
          chk("awid", awid, e.id);
          chk("awsize", awsize, 4);
          chk("awburst", awburst, 1);
        end
      end
      if (b_hs) begin
        pend--; nb++;
        m = bresp == 2'b01 ? 2'b00 : bresp;
        if (m > acc) acc = m;
      end
      if (aw_hs) begin pend++; naw++; end
      if (done_valid) chk("done_not_early", pend == 0 && q.size() == 0, 1);
      if (done_valid && done_ready) begin
        chk("done_resp", done_resp, acc);
        fin = 1;
      end
      pv = awvalid && !awready;
      pa = awaddr;
      @(negedge clk);
    end
    awready = 0; bvalid = 0; bready = 0; done_ready = 0;
    if (!fin) chk("cmd_timeout", 0, 1);
  endtask
  initial begin
    int t;
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_done_valid", done_valid, 0);
    rst = 0;
    @(negedge clk);
    chk("post_rst_cmd_ready", cmd_ready, 1);
    run_cmd(64'h0FF0, 16'd3, 4'h5, 0, 0);
    run_cmd(64'h0, 16'd511, 4'h2, 0, 0);
    run_cmd(64'h0, 16'd767, 4'h3, 1, 1);
    run_cmd(64'h0, 16'd767, 4'h1, 2, 0);
    run_cmd(64'h0, 16'd767, 4'h1, 3, 0);
    run_cmd(64'h0FF0, 16'd3, 4'hF, 0, 0);
    run_cmd(64'hFFFF_FFFF_FFFF_FFC7, 16'd20, 4'h9, 1, 0);
    for (int i = 0; i < 30; i++) begin
      logic [63:0] a;
      a = {$urandom, $urandom};
      if (i % 4 == 0) a = 64'hFFFF_FFFF_FFFF_F000 | 64'(a[11:0]);
      run_cmd(a, 16'($urandom % 600), 4'($urandom), 1, 0);
    end
    @(negedge clk);
    cmd_valid = 1; cmd_addr = 64'h0; cmd_len = 16'd40; cmd_id = 4'h1; awready = 0;
    t = 0;
    while (!cmd_ready && t < 50) begin @(negedge clk); t++; end
    @(negedge clk);
    cmd_valid = 0;
    t = 0;
    while (!awvalid && t < 50) begin @(negedge clk); t++; end
    chk("issue_before_rst", awvalid, 1);
    rst = 1;
    #1;
    chk("rst_issue_awvalid", awvalid, 0);
    chk("rst_issue_cmd_ready", cmd_ready, 0);
    chk("rst_issue_done_valid", done_valid, 0);
    @(negedge clk);
    rst = 0;
    chk("rst_release_ready_low", cmd_ready, 0);
    @(negedge clk);
    chk("rst_release_ready", cmd_ready, 1);
    run_cmd(64'h1230, 16'd300, 4'h7, 1, 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
